// File: rtl/ctrl_pipe_unit.sv
// Pipeline control unit: decodes IF/ID into a control bundle, carries it through
// ID/EX, EX/MEM and MEM/WB, and generates load-use and multi-cycle multiply stalls.
module ctrl_pipe_unit #(
  parameter int unsigned MUL_LAT = 3,
  parameter bit          EN_MUL  = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] id_instr,
  input  logic        redirect,
  input  logic        ext_stall,
  output logic [15:0] ex_ctrl,
  output logic [15:0] mem_ctrl,
  output logic [1:0]  wb_ctrl,
  output logic        stall_if_id,
  output logic        ill_instr
);

  localparam int unsigned CNT_W = 5;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SPEC2 = 6'b011100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_MUL   = 6'b000010;

  typedef enum logic {IDLE, BUSY} mul_state_t;

  mul_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [4:0]       ex_rt;
  logic [15:0]      dec_ctrl;
  logic             dec_ill;
  logic             use_rs;
  logic             use_rt;
  logic             mh;
  logic             lu;
  logic             advance;
  logic             unused_instr_bits;

  logic [5:0] opcode;
  logic [5:0] funct;
  assign opcode = id_instr[31:26];
  assign funct  = id_instr[5:0];
  assign unused_instr_bits = ^id_instr[15:6];

  // Decode also reports which source registers the instruction really reads.
  always_comb begin
    dec_ctrl = '0;
    dec_ill  = 1'b0;
    use_rs   = 1'b1;
    use_rt   = 1'b0;
    case (opcode)
      OP_ADDI: begin dec_ctrl[0] = 1'b1; dec_ctrl[11:9] = 3'd1; dec_ctrl[12] = 1'b1; end
      OP_ANDI: begin dec_ctrl[0] = 1'b1; dec_ctrl[11:9] = 3'd3; dec_ctrl[12] = 1'b1; end
      OP_ORI:  begin dec_ctrl[0] = 1'b1; dec_ctrl[11:9] = 3'd4; dec_ctrl[12] = 1'b1; end
      OP_SLTI: begin dec_ctrl[0] = 1'b1; dec_ctrl[11:9] = 3'd5; dec_ctrl[12] = 1'b1; end
      OP_LW: begin
        dec_ctrl[2:0]  = 3'b111;
        dec_ctrl[11:9] = 3'd1;
        dec_ctrl[12]   = 1'b1;
      end
      OP_SW: begin
        dec_ctrl[3]    = 1'b1;
        dec_ctrl[11:9] = 3'd1;
        dec_ctrl[12]   = 1'b1;
        use_rt         = 1'b1;
      end
      OP_BEQ:  begin dec_ctrl[4] = 1'b1; use_rt = 1'b1; end
      OP_BNE:  begin dec_ctrl[5] = 1'b1; use_rt = 1'b1; end
      OP_BGTZ: dec_ctrl[6] = 1'b1;
      OP_J:    begin dec_ctrl[8:7] = 2'd1; use_rs = 1'b0; end
      OP_JAL: begin
        dec_ctrl[0]     = 1'b1;
        dec_ctrl[8:7]   = 2'd3;
        dec_ctrl[14:13] = 2'd2;
        use_rs          = 1'b0;
      end
      OP_RTYPE: begin
        dec_ctrl[14:13] = 2'd1;
        dec_ctrl[11:9]  = 3'd2;
        use_rt          = 1'b1;
        if (funct == FN_JR) dec_ctrl[8:7] = 2'd2;
        else                dec_ctrl[0]   = 1'b1;
      end
      OP_SPEC2: begin
        if (EN_MUL && funct == FN_MUL) begin
          dec_ctrl[0]     = 1'b1;
          dec_ctrl[11:9]  = 3'd6;
          dec_ctrl[14:13] = 2'd1;
          dec_ctrl[15]    = 1'b1;
          use_rt          = 1'b1;
        end else begin
          dec_ill = 1'b1;
        end
      end
      default: dec_ill = 1'b1;
    endcase
  end

  assign lu = ex_ctrl[2] && (ex_rt != 5'd0) &&
              ((use_rs && id_instr[25:21] == ex_rt) ||
               (use_rt && id_instr[20:16] == ex_rt));
  assign mh = (state == BUSY) && (cnt != '0);
  assign advance = !redirect && !ext_stall && !mh && !lu;
  assign stall_if_id = rst_n && !redirect && (ext_stall || mh || lu);

  // The counter keeps running through ext_stall so the multiply unit's latency is wall-clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (redirect) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (advance && dec_ctrl[15] && (MUL_LAT > 1)) begin
      state <= BUSY;
      cnt   <= CNT_W'(MUL_LAT - 1);
    end else if (state == BUSY) begin
      if (cnt == '0) state <= IDLE;
      else           cnt   <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_ctrl   <= '0;
      ex_rt     <= '0;
      mem_ctrl  <= '0;
      wb_ctrl   <= '0;
      ill_instr <= 1'b0;
    end else begin
      ill_instr <= 1'b0;
      if (redirect) begin
        ex_ctrl  <= '0;
        ex_rt    <= '0;
        mem_ctrl <= '0;
        wb_ctrl  <= mem_ctrl[1:0];
      end else if (ext_stall) begin
        ex_ctrl  <= ex_ctrl;
      end else if (mh) begin
        mem_ctrl <= '0;
        wb_ctrl  <= mem_ctrl[1:0];
      end else if (lu) begin
        ex_ctrl  <= '0;
        ex_rt    <= '0;
        mem_ctrl <= ex_ctrl;
        wb_ctrl  <= mem_ctrl[1:0];
      end else begin
        ex_ctrl   <= dec_ctrl;
        ex_rt     <= id_instr[20:16];
        mem_ctrl  <= ex_ctrl;
        wb_ctrl   <= mem_ctrl[1:0];
        ill_instr <= dec_ill;
      end
    end
  end

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Bench for ctrl_pipe_unit: three configurations share one stimulus stream and are
// compared every cycle against a behavioural model, plus directed scenario checks.
module tb_ctrl_pipe_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] id_instr;
  logic        redirect;
  logic        ext_stall;
  logic [15:0] ex_o  [3];
  logic [15:0] mem_o [3];
  logic [1:0]  wb_o  [3];
  logic        stall_o [3];
  logic        ill_o   [3];

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] NOP    = 32'h00000000;
  localparam logic [31:0] ADDI   = 32'h20080005;
  localparam logic [31:0] LW8    = 32'h8C080000;
  localparam logic [31:0] ADD8   = 32'h01084820;
  localparam logic [31:0] ADD10  = 32'h014A4820;
  localparam logic [31:0] MUL    = 32'h71094002;
  localparam logic [31:0] JAL    = 32'h0C000010;

  always #5 clk = ~clk;

  ctrl_pipe_unit #(.MUL_LAT(3), .EN_MUL(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .id_instr(id_instr), .redirect(redirect), .ext_stall(ext_stall),
    .ex_ctrl(ex_o[0]), .mem_ctrl(mem_o[0]), .wb_ctrl(wb_o[0]), .stall_if_id(stall_o[0]), .ill_instr(ill_o[0]));
  ctrl_pipe_unit #(.MUL_LAT(4), .EN_MUL(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .id_instr(id_instr), .redirect(redirect), .ext_stall(ext_stall),
    .ex_ctrl(ex_o[1]), .mem_ctrl(mem_o[1]), .wb_ctrl(wb_o[1]), .stall_if_id(stall_o[1]), .ill_instr(ill_o[1]));
  ctrl_pipe_unit #(.MUL_LAT(3), .EN_MUL(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .id_instr(id_instr), .redirect(redirect), .ext_stall(ext_stall),
    .ex_ctrl(ex_o[2]), .mem_ctrl(mem_o[2]), .wb_ctrl(wb_o[2]), .stall_if_id(stall_o[2]), .ill_instr(ill_o[2]));

  // Reference model: what each stage holds, plus how long a multiply has sat in EX.
  int          lat    [3] = '{3, 4, 3};
  bit          en_mul [3] = '{1'b1, 1'b1, 1'b0};
  logic [15:0] m_ex  [3];
  logic [15:0] m_mem [3];
  logic [1:0]  m_wb  [3];
  logic        m_ill [3];
  logic [4:0]  m_rt  [3];
  bit          m_mul [3];
  int          m_age [3];
  logic        seen_stall [3];

  function automatic logic [15:0] bundle(int rw, int mtr, int mr, int mw, int br, int jmp,
                                         int alu, int src, int dst, int mul);
    int v;
    v = rw + 2*mtr + 4*mr + 8*mw + 16*br + 128*jmp + 512*alu + 4096*src + 8192*dst + 32768*mul;
    return v[15:0];
  endfunction

  function automatic logic [16:0] ref_decode(logic [31:0] ins, bit en);
    logic [5:0] op;
    logic [5:0] fn;
    op = ins[31:26];
    fn = ins[5:0];
    case (op)
      6'h08: return {1'b0, bundle(1,0,0,0,0,0,1,1,0,0)};
      6'h0C: return {1'b0, bundle(1,0,0,0,0,0,3,1,0,0)};
      6'h0D: return {1'b0, bundle(1,0,0,0,0,0,4,1,0,0)};
      6'h0A: return {1'b0, bundle(1,0,0,0,0,0,5,1,0,0)};
      6'h23: return {1'b0, bundle(1,1,1,0,0,0,1,1,0,0)};
      6'h2B: return {1'b0, bundle(0,0,0,1,0,0,1,1,0,0)};
      6'h04: return {1'b0, bundle(0,0,0,0,1,0,0,0,0,0)};
      6'h05: return {1'b0, bundle(0,0,0,0,2,0,0,0,0,0)};
      6'h07: return {1'b0, bundle(0,0,0,0,4,0,0,0,0,0)};
      6'h02: return {1'b0, bundle(0,0,0,0,0,1,0,0,0,0)};
      6'h03: return {1'b0, bundle(1,0,0,0,0,3,0,0,2,0)};
      6'h00: begin
        if (fn == 6'h08) return {1'b0, bundle(0,0,0,0,0,2,2,0,1,0)};
        return {1'b0, bundle(1,0,0,0,0,0,2,0,1,0)};
      end
      6'h1C: begin
        if (en && fn == 6'h02) return {1'b0, bundle(1,0,0,0,0,0,6,0,1,1)};
        return {1'b1, 16'h0000};
      end
      default: return {1'b1, 16'h0000};
    endcase
  endfunction

  function automatic bit load_use(int i, logic [31:0] ins);
    bit rs_used;
    bit rt_used;
    logic [5:0] op;
    op = ins[31:26];
    rs_used = !(op == 6'h02 || op == 6'h03);
    rt_used = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04) || (op == 6'h05) ||
              (op == 6'h1C && en_mul[i] && ins[5:0] == 6'h02);
    return m_ex[i][2] && (m_rt[i] != 5'd0) &&
           ((rs_used && ins[25:21] == m_rt[i]) || (rt_used && ins[20:16] == m_rt[i]));
  endfunction

  function automatic bit mul_hold(int i);
    return m_mul[i] && (m_age[i] < lat[i]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_ex[i] = '0; m_mem[i] = '0; m_wb[i] = '0; m_ill[i] = 1'b0;
      m_rt[i] = '0; m_mul[i] = 1'b0; m_age[i] = 0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      bit mh;
      bit lu;
      logic [16:0] d;
      mh = mul_hold(i);
      lu = load_use(i, id_instr);
      d  = ref_decode(id_instr, en_mul[i]);
      m_ill[i] = 1'b0;
      if (redirect) begin
        m_wb[i] = m_mem[i][1:0]; m_mem[i] = '0; m_ex[i] = '0; m_rt[i] = '0; m_mul[i] = 1'b0;
      end else if (ext_stall) begin
        if (m_mul[i]) m_age[i]++;
      end else if (mh) begin
        m_wb[i] = m_mem[i][1:0]; m_mem[i] = '0; m_age[i]++;
      end else if (lu) begin
        m_wb[i] = m_mem[i][1:0]; m_mem[i] = m_ex[i]; m_ex[i] = '0; m_rt[i] = '0; m_mul[i] = 1'b0;
      end else begin
        m_wb[i] = m_mem[i][1:0]; m_mem[i] = m_ex[i]; m_ex[i] = d[15:0];
        m_rt[i] = id_instr[20:16]; m_mul[i] = d[15]; m_age[i] = 1; m_ill[i] = d[16];
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 3; i++) begin
      logic exp_stall;
      exp_stall = rst_n && !redirect && (ext_stall || mul_hold(i) || load_use(i, id_instr));
      checkOutput($sformatf("ex%0d", i), ex_o[i], m_ex[i]);
      checkOutput($sformatf("mem%0d", i), mem_o[i], m_mem[i]);
      checkOutput($sformatf("wb%0d", i), 16'(wb_o[i]), 16'(m_wb[i]));
      checkOutput($sformatf("ill%0d", i), 16'(ill_o[i]), 16'(m_ill[i]));
      checkOutput($sformatf("stall%0d", i), 16'(stall_o[i]), 16'(exp_stall));
    end
  endtask

  task automatic check_reset_zero();
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("rst_ex%0d", i), ex_o[i], 16'h0000);
      checkOutput($sformatf("rst_mem%0d", i), mem_o[i], 16'h0000);
      checkOutput($sformatf("rst_wb%0d", i), 16'(wb_o[i]), 16'h0000);
      checkOutput($sformatf("rst_ill%0d", i), 16'(ill_o[i]), 16'h0000);
      checkOutput($sformatf("rst_stall%0d", i), 16'(stall_o[i]), 16'h0000);
    end
  endtask

  // One pipeline cycle: drive, compare against the model mid-cycle, then take the edge.
  task automatic applyStimulus(input logic [31:0] instr, input logic redir, input logic xs);
    id_instr  = instr;
    redirect  = redir;
    ext_stall = xs;
    @(negedge clk);
    compare_all();
    for (int i = 0; i < 3; i++) seen_stall[i] = stall_o[i];
    @(posedge clk);
    model_edge();
    #1;
  endtask

  logic [5:0] ops [16] = '{6'h08, 6'h0C, 6'h0D, 6'h0A, 6'h23, 6'h23, 6'h23, 6'h2B,
                           6'h04, 6'h05, 6'h07, 6'h02, 6'h03, 6'h00, 6'h1C, 6'h3F};

  initial begin
    rst_n = 1'b1; id_instr = NOP; redirect = 1'b0; ext_stall = 1'b1;
    #1 rst_n = 1'b0;
    #2 check_reset_zero();
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1; ext_stall = 1'b0;

    applyStimulus(ADDI, 0, 0); checkOutput("addi_ex", ex_o[0], 16'h1201);
    applyStimulus(NOP, 0, 0);  checkOutput("addi_mem", mem_o[0], 16'h1201);
    applyStimulus(NOP, 0, 0);  checkOutput("addi_wb", 16'(wb_o[0]), 16'h0001);

    applyStimulus(LW8, 0, 0);  checkOutput("lw_ex", ex_o[0], 16'h1207);
    applyStimulus(ADD8, 0, 0); checkOutput("lu_stall", 16'(seen_stall[0]), 16'h0001);
    checkOutput("lu_bubble", ex_o[0], 16'h0000);
    applyStimulus(ADD8, 0, 0); checkOutput("lu_release", 16'(seen_stall[0]), 16'h0000);
    checkOutput("lu_add_ex", ex_o[0], 16'h2401);
    applyStimulus(LW8, 0, 0);
    applyStimulus(ADD10, 0, 0); checkOutput("nolu_stall", 16'(seen_stall[0]), 16'h0000);
    checkOutput("nolu_ex", ex_o[0], 16'h2401);

    applyStimulus(JAL, 0, 0); checkOutput("jal_ex", ex_o[0], 16'h4181);

    applyStimulus(MUL, 0, 0);
    checkOutput("mul_ex", ex_o[0], 16'hAC01);
    checkOutput("mul_dis_ex", ex_o[2], 16'h0000);
    checkOutput("mul_dis_ill", 16'(ill_o[2]), 16'h0001);
    for (int k = 0; k < 2; k++) begin
      applyStimulus(ADDI, 0, 0);
      checkOutput("mul_hold_stall", 16'(seen_stall[0]), 16'h0001);
      checkOutput("mul_hold_ex", ex_o[0], 16'hAC01);
      checkOutput("mul_hold_mem", mem_o[0], 16'h0000);
      if (k == 0) begin
        checkOutput("mul_dis_nostall", 16'(seen_stall[2]), 16'h0000);
        checkOutput("mul_dis_pulse_end", 16'(ill_o[2]), 16'h0000);
      end
    end
    applyStimulus(ADDI, 0, 0);
    checkOutput("mul_done_stall", 16'(seen_stall[0]), 16'h0000);
    checkOutput("mul_done_ex", ex_o[0], 16'h1201);
    checkOutput("mul_done_mem", mem_o[0], 16'hAC01);

    applyStimulus(NOP, 0, 0);
    applyStimulus(NOP, 0, 0);
    applyStimulus(MUL, 0, 0);
    applyStimulus(ADDI, 1, 0);
    checkOutput("redir_stall", 16'(seen_stall[0]), 16'h0000);
    checkOutput("redir_ex", ex_o[0], 16'h0000);
    checkOutput("redir_mem", mem_o[0], 16'h0000);
    applyStimulus(ADDI, 0, 0);
    checkOutput("redir_idle_stall", 16'(seen_stall[1]), 16'h0000);
    checkOutput("redir_after_ex", ex_o[0], 16'h1201);

    applyStimulus(ADDI, 1, 1);
    checkOutput("redir_over_stall", 16'(seen_stall[0]), 16'h0000);
    checkOutput("redir_over_ex", ex_o[0], 16'h0000);
    applyStimulus(LW8, 0, 0);
    applyStimulus(ADDI, 0, 1);
    checkOutput("xstall_stall", 16'(seen_stall[0]), 16'h0001);
    checkOutput("xstall_hold", ex_o[0], 16'h1207);

    applyStimulus(NOP, 0, 0);
    applyStimulus(MUL, 0, 0);
    applyStimulus(NOP, 0, 0);
    rst_n = 1'b0; ext_stall = 1'b1;
    #2 check_reset_zero();
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1; ext_stall = 1'b0;
    applyStimulus(MUL, 0, 0); checkOutput("mul4_ex", ex_o[1], 16'hAC01);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(NOP, 0, 0);
      checkOutput("mul4_stall", 16'(seen_stall[1]), 16'h0001);
      checkOutput("mul4_hold_ex", ex_o[1], 16'hAC01);
    end
    applyStimulus(NOP, 0, 0);
    checkOutput("mul4_done_stall", 16'(seen_stall[1]), 16'h0000);
    checkOutput("mul4_done_ex", ex_o[1], 16'h2401);

    for (int n = 0; n < 400; n++) begin
      logic [31:0] ins;
      logic [5:0]  op;
      op  = ops[$urandom_range(0, 15)];
      ins = {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)};
      if (op == 6'h00) begin
        case ($urandom_range(0, 2))
          0:       ins[5:0] = 6'h20;
          1:       ins[5:0] = 6'h08;
          default: ins[5:0] = 6'h2A;
        endcase
      end else if (op == 6'h1C) begin
        ins[5:0] = ($urandom_range(0, 3) == 0) ? 6'h00 : 6'h02;
      end
      applyStimulus(ins, 1'($urandom_range(0, 99) < 8), 1'($urandom_range(0, 99) < 15));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe_unit.md
# ctrl_pipe_unit

Parametrised successor to the single-stage pipeline control unit. It decodes the IF/ID instruction into a packed control bundle and carries that bundle through three registered stages: ID/EX, EX/MEM and MEM/WB. It also detects load-use hazards and sequences a multi-cycle multiply, generating its own stall and bubble control. It sits between the IF/ID register and the datapath stage registers, and drives the PC/IF/ID freeze.

## Interface
- MUL_LAT, 3: cycles a `mul` occupies EX; legal range 1..16.
- EN_MUL, 1: 1 = decode `mul`; 0 = `mul` is illegal.
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous, active-low reset
- id_instr  in  32  instruction currently in IF/ID
- redirect  in  1  taken branch or jump resolved by the instruction in MEM; flushes ID and EX
- ext_stall  in  1  memory busy; freezes all stages
- ex_ctrl  out  16  ID/EX control bundle
- mem_ctrl  out  16  EX/MEM control bundle, same layout as ex_ctrl
- wb_ctrl  out  2  MEM/WB control: {MemtoReg, RegWrite}
- stall_if_id  out  1  hold PC and IF/ID this cycle (combinational)
- ill_instr  out  1  registered one-cycle pulse when an undecodable instruction is accepted

## Operation
- Bundle layout:
  - [0] RegWrite, [1] MemtoReg, [2] MemRead, [3] MemWrite
  - [4] Branch_beq, [5] Branch_bne, [6] Branch_bgtz
  - [8:7] jump: 0 none, 1 j, 2 jr, 3 jal
  - [11:9] ALUOp: 0 sub, 1 add, 2 funct, 3 and, 4 or, 5 slt, 6 mul
  - [12] ALUSrc
  - [14:13] RegDst: 0 rt, 1 rd, 2 r31
  - [15] IsMul
- Decode by opcode [31:26]:
  - addi 001000: RegWrite, ALUOp=1, ALUSrc
  - andi 001100: ALUOp=3, ALUSrc, RegWrite
  - ori 001101: ALUOp=4, ALUSrc, RegWrite
  - slti 001010: ALUOp=5, ALUSrc, RegWrite
  - lw 100011: RegWrite, MemtoReg, MemRead, ALUOp=1, ALUSrc
  - sw 101011: MemWrite, ALUOp=1, ALUSrc
  - beq 000100, bne 000101, bgtz 000111: respective Branch bit, ALUOp=0
  - j 000010: jump=1
  - jal 000011: jump=3, RegDst=2, RegWrite
  - R-type 000000: RegDst=1, ALUOp=2, RegWrite. Exception: funct 001000 (jr) gives jump=2 and RegWrite=0.
  - 011100 with funct 000010 and EN_MUL=1 (mul): RegDst=1, ALUOp=6, RegWrite, IsMul.
  - Anything else: all-zero bundle, and ill_instr=1 on the next edge.
- Source use for hazard checks:
  - rs = [25:21] is read by everything except j and jal.
  - rt = [20:16] is read by R-type, sw, beq, bne and mul.
- An internal register ex_rt captures id_instr[20:16] together with ex_ctrl.
- Load-use: `lu` = ex_ctrl[2] & ex_rt≠0 & ex_rt equals a used source of id_instr.
- Multiply FSM, states IDLE and BUSY:
  - On the edge a mul enters ID/EX with MUL_LAT>1, the counter loads MUL_LAT-1 and the state goes to BUSY.
  - In BUSY the counter decrements every cycle, including during ext_stall.
  - At 0 the state returns to IDLE.
  - `mh` = BUSY & cnt≠0.
- Per-edge priority, highest first:
  1. redirect: ID/EX←0, EX/MEM←0, MEM/WB←mem_ctrl, FSM→IDLE, cnt←0.
  2. ext_stall: all stage registers hold.
  3. mh: ID/EX holds, EX/MEM←0, MEM/WB advances.
  4. lu: ID/EX←0, downstream stages advance.
  5. Otherwise all stages advance and ID/EX←decode(id_instr).
- stall_if_id = ~redirect & (ext_stall | mh | lu).
- ill_instr is asserted only under rule 5.

## Timing
- Reset (asynchronous, any state including mid-multiply) clears:
  - ex_ctrl, mem_ctrl and wb_ctrl to 0
  - ill_instr to 0
  - ex_rt to 0
  - cnt to 0, FSM to IDLE
- stall_if_id reads 0 while in reset.
- Decode latency is 1 edge to ex_ctrl; 2 to mem_ctrl; 3 to wb_ctrl.
- A mul stays exactly MUL_LAT cycles in ex_ctrl when unstalled.
  - stall_if_id is high for MUL_LAT-1 of those cycles.
  - mem_ctrl is 0 for MUL_LAT-1 cycles behind the mul.
- A load-use bubble costs exactly 1 cycle.
- Back-to-back muls: the second mul sees no load-use; the FSM reloads on the edge where it enters EX.
- If redirect and ext_stall are high together, redirect wins.
- If lu and mh are high together, mh wins; lu is re-evaluated after the hold ends.

## Test plan
- rst_n pulsed low mid-BUSY with MUL_LAT=4 → all outputs 0 immediately; stall_if_id=0; the next mul takes a full 4 cycles.
- id_instr=0x20080005 (addi) → next edge ex_ctrl=0x1201; 2 edges mem_ctrl=0x1201; 3 edges wb_ctrl=2'b01.
- 0x8C080000 (lw $8) then 0x01084820 (add $9,$8,$8):
  - stall_if_id=1 for one cycle, then ex_ctrl=0 bubble, then ex_ctrl=0x2401.
  - The same pair with add reading $10 → no stall.
- MUL_LAT=3, 0x71094002 (mul):
  - ex_ctrl=0xAC01 for 3 cycles; stall_if_id high 2 cycles; mem_ctrl 0 for 2 cycles, then 0xAC01.
- redirect asserted in the first BUSY cycle → next edge ex_ctrl=0, mem_ctrl=0, FSM IDLE; stall_if_id=0 on the following cycle.
- 0x0C000010 (jal) → ex_ctrl=0x4181.
- EN_MUL=0 with 0x71094002 → ex_ctrl=0 and a 1-cycle ill_instr pulse; no stall.
